audio_out_serializer: RTL and testbench
=======================================

# audio_out_serializer

Transmit-side I2S serializer for the audio controller's DAC path. Accepts stereo sample pairs over a valid/ready handshake and buffers them in a small FIFO. Shifts each channel out MSB-first on the serial data line, bit-aligned to the frame window that the bit-counter stage flags with `counting`. Sits between the audio stream source and the codec's DACDAT pin, and consumes the same edge strobes as the bit counter.

## Interface
- DATA_WIDTH, 16, bits per channel sample; legal 8..32
- FIFO_DEPTH, 4, stereo pairs buffered; power of two, at least 2
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- clear_fifo  in  1  flush buffered pairs; shift registers unaffected
- bit_clk_rising_edge  in  1  one-cycle strobe
- bit_clk_falling_edge  in  1  one-cycle strobe
- left_right_clk_rising_edge  in  1  strobe; right-channel frame starts
- left_right_clk_falling_edge  in  1  strobe; left-channel frame starts
- counting  in  1  bit-window flag from the bit counter stage
- sample_valid  in  1  producer offers a pair
- sample_left  in  DATA_WIDTH  left sample, two's complement
- sample_right  in  DATA_WIDTH  right sample
- sample_ready  out  1  pair accepted when valid && ready
- fifo_space  out  $clog2(FIFO_DEPTH)+1  free pair slots
- underrun  out  1  one-cycle pulse; frame started with FIFO empty
- serial_audio_out_data  out  1  registered DACDAT

## Operation
- Push: on sample_valid && sample_ready, {left,right} is written to the FIFO.
- sample_ready is !full && !clear_fifo && !reset, and is combinational.
- Left frame: on left_right_clk_falling_edge:
  - If the FIFO is not empty, pop one entry, load left into the shift register and right into the holding register.
  - If the FIFO is empty, load zeros into both and pulse underrun.
- Right frame: on left_right_clk_rising_edge, load the holding register into the shift register. This never pops and never underruns.
- On either LR edge, reload bits_left with DATA_WIDTH.
- Shift: on bit_clk_falling_edge with counting=1, no LR edge in the same cycle, and bits_left>0:
  - serial_audio_out_data takes shift_reg[MSB].
  - The shift register moves left with 0 shifted in.
  - bits_left is decremented.
- Pad: in any other bit_clk_falling_edge cycle, serial_audio_out_data is driven 0. This covers bits_left=0 and counting=0.
- Pairing: a pair always leaves atomically. A right channel never plays without its own left.
- FIFO push/pop in the same cycle:
  - Both occur; the count is unchanged.
  - When full, the push is blocked by ready.
  - When empty, there is no bypass: the pop underruns even if a push lands in that cycle.
- clear_fifo: pointers are zeroed that cycle and any pop in that cycle is suppressed, producing underrun behaviour. The frame currently shifting completes.

## Timing
- Reset values:
  - sample_ready=0, fifo_space=FIFO_DEPTH, underrun=0, serial_audio_out_data=0.
  - Shift and holding registers 0, bits_left=0.
- sample_ready is 1 in the first cycle after reset deasserts.
- The LR edge coincides with a BCLK falling edge, and that cycle only loads. The MSB appears on the next falling edge, giving the required I2S one-bit delay.
- serial_audio_out_data changes only in bit_clk_falling_edge cycles. It is registered, so it is valid one clk after the strobe and stable across the BCLK rising edge.
- fifo_space reflects a push or pop from the next cycle onward.
- underrun is high for exactly the cycle after the empty LR falling edge.
- Reset mid-frame: all state clears immediately. Output stays 0 until the first full left frame after a left_right_clk_falling_edge.

## Configuration
- AUDIO_OUT_UNDERRUN_CNT_EN defined:
  - Adds output underrun_count [UNDERRUN_CNT_WIDTH-1:0].
  - The counter increments with each underrun pulse and saturates at all-ones.
  - It is cleared by reset or clear_fifo.
- Not defined: the port and counter are absent; only the underrun pulse remains.

## Structure
- Package audio_out_pkg holds:
  - MAX_DATA_WIDTH=32
  - UNDERRUN_CNT_WIDTH=16
  - channel enum CH_LEFT=0, CH_RIGHT=1
- Sub-module audio_sample_fifo: synchronous FIFO, width 2*DATA_WIDTH, depth FIFO_DEPTH, with full/empty/level outputs and a clear input.
- The serializer top holds the shift register, holding register, bits_left counter and underrun logic.

## Test plan
- DATA_WIDTH=16, push {16'hA5C3, 16'h0F0F}, run one full LR period:
  - Left bits are 1010010111000011, starting the second BCLK falling edge after the LRCLK fall.
  - Right bits are 0000111100001111.
  - All remaining slots are 0.
- Push 4 pairs with FIFO_DEPTH=4:
  - fifo_space reads 0 and sample_ready=0.
  - A 5th valid is held, then accepted on the cycle after the next left frame pops.
- No pushes:
  - Each left frame pulses underrun and outputs all zeros.
  - With the macro, underrun_count reads 3 after 3 frames.
- Push in the same cycle as left_right_clk_falling_edge with the FIFO empty:
  - underrun pulses and the frame outputs zeros.
  - The pair plays on the following frame.
- Assert reset mid-left-frame after 5 bits:
  - Output goes 0 immediately, fifo_space=FIFO_DEPTH.
  - No bits appear until a new pair is pushed and played.
- Assert clear_fifo with 3 pairs queued during a right frame:
  - The right channel finishes intact.
  - The next left frame underruns and fifo_space=FIFO_DEPTH.

Source files
------------

// File: rtl/audio_out_pkg.sv
// Shared constants and types for the DAC-side audio serializer.
// Optional feature macro: AUDIO_OUT_UNDERRUN_CNT_EN (adds an underrun event counter).
package audio_out_pkg;

    // Widest channel sample the serializer is built to carry
    localparam int MAX_DATA_WIDTH = 32;

    // Width of the optional saturating underrun counter
    localparam int UNDERRUN_CNT_WIDTH = 16;

    // Channel identifiers within a stereo pair
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous stereo-pair FIFO with first-word-fall-through read data,
// so the head pair is already presented in the cycle it is popped.
// Optional feature macro used elsewhere: AUDIO_OUT_UNDERRUN_CNT_EN (not used here).
module audio_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    // A flush wins over any access in the same cycle
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign level   = count_reg;
    assign rd_data = mem[rd_ptr_reg];

    // Storage array: written at the tail, no reset needed on the data
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/audio_out_serializer.sv
// I2S transmit serializer: buffers stereo pairs, shifts each channel MSB-first
// on BCLK falling edges inside the counting window, with one-bit I2S delay.
// Optional feature macro: AUDIO_OUT_UNDERRUN_CNT_EN adds a saturating underrun_count output.
module audio_out_serializer
    import audio_out_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear_fifo,
    input  logic                          bit_clk_rising_edge,
    input  logic                          bit_clk_falling_edge,
    input  logic                          left_right_clk_rising_edge,
    input  logic                          left_right_clk_falling_edge,
    input  logic                          counting,
    input  logic                          sample_valid,
    input  logic [DATA_WIDTH-1:0]         sample_left,
    input  logic [DATA_WIDTH-1:0]         sample_right,
    output logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_space,
    output logic                          underrun,
    output logic                          serial_audio_out_data
`ifdef AUDIO_OUT_UNDERRUN_CNT_EN
    ,
    output logic [UNDERRUN_CNT_WIDTH-1:0] underrun_count
`endif
);
    localparam int PAIR_W = 2 * DATA_WIDTH;
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BL_W   = $clog2(DATA_WIDTH + 1);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LVL_W-1:0]      fifo_level;
    logic [PAIR_W-1:0]     fifo_rd_data;
    logic [DATA_WIDTH-1:0] head_left;
    logic [DATA_WIDTH-1:0] head_right;
    logic                  push;
    logic                  pop;
    logic                  frame_empty;
    logic                  lr_edge;
    logic                  shift_en;

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic [BL_W-1:0]       bits_left_reg;
    logic                  data_reg;
    logic                  underrun_reg;

    // Data only moves on BCLK falling edges; the rising strobe is part of the
    // shared edge bundle but carries no work here.
    logic unused_rising;
    assign unused_rising = bit_clk_rising_edge;

    assign sample_ready = !fifo_full && !clear_fifo && !reset;
    assign push         = sample_valid && sample_ready;

    // No bypass: a pair pushed in the LR-fall cycle waits for the next left frame.
    // A flush in the LR-fall cycle also counts as an empty frame start.
    assign frame_empty  = fifo_empty || clear_fifo;
    assign pop          = left_right_clk_falling_edge && !frame_empty;

    assign lr_edge  = left_right_clk_falling_edge || left_right_clk_rising_edge;
    assign shift_en = bit_clk_falling_edge && counting && !lr_edge && (bits_left_reg != '0);

    assign fifo_space            = LVL_W'(FIFO_DEPTH) - fifo_level;
    assign underrun              = underrun_reg;
    assign serial_audio_out_data = data_reg;

    audio_sample_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_fifo),
        .push    (push),
        .pop     (pop),
        .wr_data ({sample_left, sample_right}),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Split the head pair into its left (upper) and right (lower) halves
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_split
        assign head_left[gi]  = fifo_rd_data[DATA_WIDTH + gi];
        assign head_right[gi] = fifo_rd_data[gi];
    end

    // Frame loading and MSB-first shifting; the pair leaves the FIFO as a unit
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg     <= '0;
            hold_reg      <= '0;
            bits_left_reg <= '0;
        end else if (left_right_clk_falling_edge) begin
            shift_reg     <= pop ? head_left  : '0;
            hold_reg      <= pop ? head_right : '0;
            bits_left_reg <= BL_W'(DATA_WIDTH);
        end else if (left_right_clk_rising_edge) begin
            shift_reg     <= hold_reg;
            bits_left_reg <= BL_W'(DATA_WIDTH);
        end else if (shift_en) begin
            shift_reg     <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
            bits_left_reg <= bits_left_reg - BL_W'(1);
        end
    end

    // Registered DACDAT: updates only on BCLK falling strobes, pads with 0
    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg <= 1'b0;
        end else if (bit_clk_falling_edge) begin
            data_reg <= shift_en ? shift_reg[DATA_WIDTH-1] : 1'b0;
        end
    end

    // One-cycle underrun pulse after a left frame starts with nothing to play
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_reg <= 1'b0;
        end else begin
            underrun_reg <= left_right_clk_falling_edge && frame_empty;
        end
    end

`ifdef AUDIO_OUT_UNDERRUN_CNT_EN
    logic [UNDERRUN_CNT_WIDTH-1:0] underrun_count_reg;

    assign underrun_count = underrun_count_reg;

    // Saturating count of underrun pulses, zeroed by reset or a flush
    always_ff @(posedge clk) begin
        if (reset || clear_fifo) begin
            underrun_count_reg <= '0;
        end else if (underrun_reg && (underrun_count_reg != '1)) begin
            underrun_count_reg <= underrun_count_reg + UNDERRUN_CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_audio_out_serializer.sv
// Self-checking bench for audio_out_serializer: drives BCLK/LRCLK strobes,
// keeps a queue-based model of buffered pairs and the expected bit stream.
// Optional feature macro: AUDIO_OUT_UNDERRUN_CNT_EN (underrun_count checks).
module tb_audio_out_serializer;
    localparam int DW         = 16;
    localparam int DEPTH      = 4;
    localparam int LVL_W      = $clog2(DEPTH) + 1;
    localparam int HALF_BCLKS = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear_fifo = 1'b0;
    logic bit_clk_rising_edge = 1'b0;
    logic bit_clk_falling_edge = 1'b0;
    logic left_right_clk_rising_edge = 1'b0;
    logic left_right_clk_falling_edge = 1'b0;
    logic counting = 1'b0;
    logic sample_valid = 1'b0;
    logic [DW-1:0] sample_left = '0;
    logic [DW-1:0] sample_right = '0;
    logic sample_ready;
    logic [LVL_W-1:0] fifo_space;
    logic underrun;
    logic serial_audio_out_data;
`ifdef AUDIO_OUT_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif

    always #5 clk = ~clk;

    audio_out_serializer #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                         (clk),
        .reset                       (reset),
        .clear_fifo                  (clear_fifo),
        .bit_clk_rising_edge         (bit_clk_rising_edge),
        .bit_clk_falling_edge        (bit_clk_falling_edge),
        .left_right_clk_rising_edge  (left_right_clk_rising_edge),
        .left_right_clk_falling_edge (left_right_clk_falling_edge),
        .counting                    (counting),
        .sample_valid                (sample_valid),
        .sample_left                 (sample_left),
        .sample_right                (sample_right),
        .sample_ready                (sample_ready),
        .fifo_space                  (fifo_space),
        .underrun                    (underrun),
        .serial_audio_out_data       (serial_audio_out_data)
`ifdef AUDIO_OUT_UNDERRUN_CNT_EN
        ,
        .underrun_count              (underrun_count)
`endif
    );

    // Reference model: queued pairs, the word being played and the right-channel hold
    logic [2*DW-1:0] model_q[$];
    logic [DW-1:0]   cur_word = '0;
    logic [DW-1:0]   hold_word = '0;
    int              uc_model = 0;
    int              checks = 0;
    int              passes = 0;

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        clear_fifo = 1'b0;
        bit_clk_falling_edge = 1'b0;
        bit_clk_rising_edge = 1'b0;
        left_right_clk_falling_edge = 1'b0;
        left_right_clk_rising_edge = 1'b0;
        counting = 1'b0;
        sample_valid = 1'b0;
        model_q.delete();
        cur_word = '0;
        hold_word = '0;
        uc_model = 0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (serial_audio_out_data !== 1'b0) $display("FAIL reset_serial got %b want 0", serial_audio_out_data);
        else passes++;
        checks++;
        if (underrun !== 1'b0) $display("FAIL reset_underrun got %b want 0", underrun);
        else passes++;
        checks++;
        if (fifo_space !== LVL_W'(DEPTH)) $display("FAIL reset_fifo_space got %0d want %0d", fifo_space, DEPTH);
        else passes++;
        checks++;
        if (sample_ready !== 1'b0) $display("FAIL reset_ready_in_reset got %b want 0", sample_ready);
        else passes++;
        reset = 1'b0;
        #1;
        checks++;
        if (sample_ready !== 1'b1) $display("FAIL reset_ready_after got %b want 1", sample_ready);
        else passes++;
    endtask

    task automatic do_push(input logic [2*DW-1:0] pair);
        int occ;
        bit exp_ready;
        @(negedge clk);
        occ = model_q.size();
        sample_valid = 1'b1;
        {sample_left, sample_right} = pair;
        #1;
        exp_ready = (occ < DEPTH);
        checks++;
        if (sample_ready !== exp_ready) $display("FAIL push_ready got %b want %b (queued %0d)", sample_ready, exp_ready, occ);
        else passes++;
        if (exp_ready) model_q.push_back(pair);
        @(negedge clk);
        sample_valid = 1'b0;
        checks++;
        if (fifo_space !== LVL_W'(DEPTH - model_q.size()))
            $display("FAIL push_fifo_space got %0d want %0d", fifo_space, DEPTH - model_q.size());
        else passes++;
    endtask

    // One LR half period: BCLK period is 4 clk, LR edge on BCLK index 0
    task automatic run_half(input bit is_left, input bit push_edge, input bit hold_valid,
                            input int rst_k, input int clr_k);
        logic [2*DW-1:0] edge_pair;
        logic [2*DW-1:0] held_pair;
        logic [2*DW-1:0] popped;
        bit exp_under;
        bit exp_ready;
        bit exp_bit;
        int occ;
        int accept_step;
        int step;
        edge_pair = {DW'($urandom), DW'($urandom)};
        held_pair = {DW'($urandom), DW'($urandom)};
        exp_under = 1'b0;
        accept_step = -1;
        step = 0;
        for (int k = 0; k < HALF_BCLKS; k++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                // registered outputs, reflecting the previous posedge
                if (c == 1) begin
                    exp_bit = (k >= 1 && k <= DW) ? cur_word[DW-k] : 1'b0;
                    checks++;
                    if (serial_audio_out_data !== exp_bit)
                        $display("FAIL serial %s k=%0d got %b want %b", is_left ? "left" : "right", k, serial_audio_out_data, exp_bit);
                    else passes++;
                end
                if (k == 0 && c == 1) begin
                    checks++;
                    if (underrun !== exp_under) $display("FAIL underrun_pulse got %b want %b", underrun, exp_under);
                    else passes++;
                end
                if (k == 0 && c == 2) begin
                    checks++;
                    if (underrun !== 1'b0) $display("FAIL underrun_width got %b want 0", underrun);
                    else passes++;
                end
                if (c == 3) begin
                    checks++;
                    if (fifo_space !== LVL_W'(DEPTH - model_q.size()))
                        $display("FAIL fifo_space k=%0d got %0d want %0d", k, fifo_space, DEPTH - model_q.size());
                    else passes++;
                end
                if (k == rst_k && c == 3) begin
                    checks++;
                    if (serial_audio_out_data !== 1'b0) $display("FAIL reset_mid_serial got %b want 0", serial_audio_out_data);
                    else passes++;
                end
`ifdef AUDIO_OUT_UNDERRUN_CNT_EN
                if (k == 0 && c == 3) begin
                    checks++;
                    if (underrun_count !== 16'(uc_model)) $display("FAIL underrun_count got %0d want %0d", underrun_count, uc_model);
                    else passes++;
                end
`endif
                // drive the inputs for the coming posedge
                occ = model_q.size();
                bit_clk_falling_edge = (c == 0);
                bit_clk_rising_edge = (c == 2);
                left_right_clk_falling_edge = (c == 0 && k == 0 && is_left);
                left_right_clk_rising_edge = (c == 0 && k == 0 && !is_left);
                counting = (k <= 17);
                reset = (k == rst_k && c == 2);
                clear_fifo = (k == clr_k && c == 2);
                if (hold_valid && accept_step < 0) begin
                    sample_valid = 1'b1;
                    {sample_left, sample_right} = held_pair;
                end else if (push_edge && k == 0 && c == 0) begin
                    sample_valid = 1'b1;
                    {sample_left, sample_right} = edge_pair;
                end else begin
                    sample_valid = 1'b0;
                end
                if (k == 0 && c == 0) begin
                    if (is_left) begin
                        if (occ == 0) begin
                            exp_under = 1'b1;
                            cur_word = '0;
                            hold_word = '0;
                            if (uc_model < 65535) uc_model++;
                        end else begin
                            popped = model_q.pop_front();
                            cur_word = popped[2*DW-1:DW];
                            hold_word = popped[DW-1:0];
                        end
                    end else begin
                        cur_word = hold_word;
                    end
                end
                if (reset) begin
                    model_q.delete();
                    cur_word = '0;
                    hold_word = '0;
                    uc_model = 0;
                end
                if (clear_fifo) begin
                    model_q.delete();
                    uc_model = 0;
                end
                #1;
                exp_ready = !reset && !clear_fifo && (occ < DEPTH);
                checks++;
                if (sample_ready !== exp_ready) $display("FAIL ready k=%0d c=%0d got %b want %b", k, c, sample_ready, exp_ready);
                else passes++;
                if (sample_valid && exp_ready) begin
                    model_q.push_back({sample_left, sample_right});
                    if (hold_valid && accept_step < 0) accept_step = step;
                end
                step++;
            end
        end
        if (hold_valid) begin
            checks++;
            if (accept_step != 1) $display("FAIL held_accept_step got %0d want 1", accept_step);
            else passes++;
        end
        reset = 1'b0;
        clear_fifo = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
    endtask

    task automatic test_known_pattern;
        do_reset();
        do_push({16'hA5C3, 16'h0F0F});
        run_half(1'b1, 1'b0, 1'b0, -1, -1);
        run_half(1'b0, 1'b0, 1'b0, -1, -1);
        run_half(1'b1, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_random_stream;
        int n;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) do_push({DW'($urandom), DW'($urandom)});
            run_half(1'b1, 1'b0, 1'b0, -1, -1);
            run_half(1'b0, 1'b0, 1'b0, -1, -1);
        end
    endtask

    task automatic test_back_pressure;
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) do_push({DW'($urandom), DW'($urandom)});
        run_half(1'b1, 1'b0, 1'b1, -1, -1);
        run_half(1'b0, 1'b0, 1'b0, -1, -1);
        run_half(1'b1, 1'b0, 1'b0, -1, -1);
        run_half(1'b0, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_underrun;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_half(1'b1, 1'b0, 1'b0, -1, -1);
            run_half(1'b0, 1'b0, 1'b0, -1, -1);
        end
`ifdef AUDIO_OUT_UNDERRUN_CNT_EN
        @(negedge clk);
        checks++;
        if (underrun_count !== 16'd3) $display("FAIL underrun_count_three got %0d want 3", underrun_count);
        else passes++;
`endif
    endtask

    task automatic test_push_at_edge;
        do_reset();
        run_half(1'b1, 1'b1, 1'b0, -1, -1);
        run_half(1'b0, 1'b0, 1'b0, -1, -1);
        run_half(1'b1, 1'b0, 1'b0, -1, -1);
        run_half(1'b0, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_reset_mid_frame;
        do_reset();
        do_push({DW'($urandom), DW'($urandom)});
        do_push({DW'($urandom), DW'($urandom)});
        run_half(1'b1, 1'b0, 1'b0, 5, -1);
        run_half(1'b0, 1'b0, 1'b0, -1, -1);
        run_half(1'b1, 1'b0, 1'b0, -1, -1);
        do_push({DW'($urandom), DW'($urandom)});
        run_half(1'b0, 1'b0, 1'b0, -1, -1);
        run_half(1'b1, 1'b0, 1'b0, -1, -1);
        run_half(1'b0, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_clear;
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_push({DW'($urandom), DW'($urandom)});
        run_half(1'b1, 1'b0, 1'b0, -1, -1);
        run_half(1'b0, 1'b0, 1'b0, -1, 8);
        run_half(1'b1, 1'b0, 1'b0, -1, -1);
        run_half(1'b0, 1'b0, 1'b0, -1, -1);
    endtask

    initial begin
        test_reset();
        test_known_pattern();
        test_random_stream();
        test_back_pressure();
        test_underrun();
        test_push_at_edge();
        test_reset_mid_frame();
        test_clear();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
